pack_rd: RTL

- Read side of the ping-pong sample buffers filled by the pack writer (X/Y/Z/UTC/NS RAMs, 4k deep; two 2048-entry halves selected by address bit 11).
- On each syn_vld it latches the half just completed and its sample count, then reads that half sample by sample.
- Emits one framed 32-bit packet per second on a valid/ready stream toward the uplink/pack transmitter.

---
 rtl/pack_rd_pkg.sv | 30 +++
 rtl/pack_rd_if.sv | 26 ++
 rtl/pack_rd_lat.sv | 24 ++
 rtl/pack_rd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pack_rd_pkg.sv
// rtl/pack_rd_pkg.sv - shared constants, state encoding and helpers for the pack reader
package pack_rd_pkg;

    localparam int          RD_LAT    = 2;
    localparam logic [15:0] SYNC_WORD = 16'hEB90;
    localparam logic [10:0] MAX_CNT   = 11'd2000;
    localparam int          HALF_SIZE = 2048;
    localparam int          IDX_W     = $clog2(HALF_SIZE);

    // Order in which the five sample fields leave the block
    localparam logic [2:0] W_UTC = 3'd0;
    localparam logic [2:0] W_NS  = 3'd1;
    localparam logic [2:0] W_X   = 3'd2;
    localparam logic [2:0] W_Y   = 3'd3;
    localparam logic [2:0] W_Z   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RADDR,
        ST_EMIT,
        ST_CSUM
    } state_t;

    // A half holds at most 2048 entries but only MAX_CNT samples are framed
    function automatic logic [IDX_W-1:0] clamp_cnt(input logic [IDX_W-1:0] raw);
        return (raw > MAX_CNT) ? MAX_CNT : raw;
    endfunction

endpackage

// File: rtl/pack_rd_if.sv
// rtl/pack_rd_if.sv - framed packet stream toward the uplink transmitter
interface pack_rd_if;

    logic [31:0] pk_data;
    logic        pk_vld;
    logic        pk_rdy;
    logic        pk_sop;
    logic        pk_eop;

    modport master (
        output pk_data,
        output pk_vld,
        output pk_sop,
        output pk_eop,
        input  pk_rdy
    );

    modport slave (
        input  pk_data,
        input  pk_vld,
        input  pk_sop,
        input  pk_eop,
        output pk_rdy
    );

endinterface

// File: rtl/pack_rd_lat.sv
// rtl/pack_rd_lat.sv - delay line that marks when RAM read data is valid
module pack_rd_lat #(
    parameter int DEPTH = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic go,
    output logic strobe
);

    logic [DEPTH-1:0] sr;

    // Walk the launch pulse through DEPTH stages so it lands on valid q_* data
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(go);
        end
    end

    assign strobe = sr[DEPTH-1];

endmodule

// File: rtl/pack_rd.sv
// rtl/pack_rd.sv - reads a completed ping-pong half and frames it as one packet
module pack_rd
    import pack_rd_pkg::*;
(
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          syn_vld,
    input  logic [11:0]   buf_waddr,
    output logic [11:0]   buf_raddr,
    input  logic [31:0]   q_x,
    input  logic [31:0]   q_y,
    input  logic [31:0]   q_z,
    input  logic [31:0]   q_utc,
    input  logic [31:0]   q_ns,
    pack_rd_if.master     pk,
    output logic          busy,
    output logic          err_ovr,
    input  logic          ovr_clr
);

    state_t           state;
    logic             half;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] start_cnt;
    logic [2:0]       w;
    logic [31:0]      checksum;
    logic [31:0]      h_ns;
    logic [31:0]      h_x;
    logic [31:0]      h_y;
    logic [31:0]      h_z;
    logic [31:0]      next_word;
    logic             lat_go;
    logic             cap;
    logic             xfer;

    assign start_cnt = clamp_cnt(buf_waddr[IDX_W-1:0]);
    assign xfer      = pk.pk_vld & pk.pk_rdy;

    // lat_go is high in the first cycle the new address is on buf_raddr
    pack_rd_lat #(
        .DEPTH (RD_LAT)
    ) u_lat (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .go      (lat_go),
        .strobe  (cap)
    );

    // Word that follows the current one within a sample (UTC is sent straight from q_utc)
    always_comb begin
        next_word = h_ns;
        case (w)
            W_NS:    next_word = h_x;
            W_X:     next_word = h_y;
            W_Y:     next_word = h_z;
            default: next_word = h_ns;
        endcase
    end

    // Packet sequencer: header, per-sample read and five words, then checksum
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            half       <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            w          <= W_UTC;
            checksum   <= '0;
            h_ns       <= '0;
            h_x        <= '0;
            h_y        <= '0;
            h_z        <= '0;
            lat_go     <= 1'b0;
            buf_raddr  <= '0;
            pk.pk_data <= '0;
            pk.pk_vld  <= 1'b0;
            pk.pk_sop  <= 1'b0;
            pk.pk_eop  <= 1'b0;
            busy       <= 1'b0;
            err_ovr    <= 1'b0;
        end else begin
            lat_go <= 1'b0;

            // A second boundary while a packet is still going is dropped and flagged
            if (ovr_clr) begin
                err_ovr <= 1'b0;
            end else if (syn_vld && busy) begin
                err_ovr <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (syn_vld) begin
                        half       <= buf_waddr[11];
                        cnt        <= start_cnt;
                        idx        <= '0;
                        busy       <= 1'b1;
                        pk.pk_vld  <= 1'b1;
                        pk.pk_sop  <= 1'b1;
                        pk.pk_data <= {SYNC_WORD, 5'b0, start_cnt};
                        state      <= ST_HDR;
                    end
                end

                ST_HDR: begin
                    if (xfer) begin
                        checksum  <= '0;
                        pk.pk_sop <= 1'b0;
                        if (cnt == '0) begin
                            pk.pk_eop  <= 1'b1;
                            pk.pk_data <= '0;
                            state      <= ST_CSUM;
                        end else begin
                            pk.pk_vld <= 1'b0;
                            buf_raddr <= {half, idx};
                            lat_go    <= 1'b1;
                            state     <= ST_RADDR;
                        end
                    end
                end

                ST_RADDR: begin
                    if (cap) begin
                        h_ns       <= q_ns;
                        h_x        <= q_x;
                        h_y        <= q_y;
                        h_z        <= q_z;
                        w          <= W_UTC;
                        pk.pk_data <= q_utc;
                        pk.pk_vld  <= 1'b1;
                        state      <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (xfer) begin
                        checksum <= checksum + pk.pk_data;
                        if (w == W_Z) begin
                            if (idx == cnt - 1'b1) begin
                                pk.pk_eop  <= 1'b1;
                                pk.pk_data <= checksum + pk.pk_data;
                                state      <= ST_CSUM;
                            end else begin
                                idx       <= idx + 1'b1;
                                buf_raddr <= {half, idx + 1'b1};
                                lat_go    <= 1'b1;
                                pk.pk_vld <= 1'b0;
                                state     <= ST_RADDR;
                            end
                        end else begin
                            w          <= w + 3'd1;
                            pk.pk_data <= next_word;
                        end
                    end
                end

                ST_CSUM: begin
                    if (xfer) begin
                        pk.pk_vld <= 1'b0;
                        pk.pk_eop <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
